// File: rtl/issue_queue.sv
// Decode-to-execute issue queue: a circular FIFO that accepts up to two decoded
// instructions per cycle and presents an in-order, hazard-checked issue pair.
package issue_queue_pkg;

    localparam logic [5:0] REG_HI = 6'd32;
    localparam logic [5:0] REG_LO = 6'd33;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  dest;
        logic [5:0]  src1;
        logic [5:0]  src2;
        logic        rf_we;
        logic        use_src1;
        logic        use_src2;
        logic        is_alu1_op;
        logic        is_alu2_op;
        logic        is_mul_div_op;
        logic        is_sp_op;
        logic        is_ls_op;
        logic        is_br_op;
    } decoded_inst_t;

endpackage

module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic [1:0]                in_valid,
    input  decoded_inst_t [1:0]       in_inst,
    output logic                      in_ready,
    output logic [1:0]                out_valid,
    output decoded_inst_t [1:0]       out_inst,
    input  logic                      out_ready,
    output logic [PTR_W:0]            occupancy
);

    localparam int CNT_W = PTR_W + 1;

    decoded_inst_t      mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [PTR_W-1:0]   head_plus1;
    logic [PTR_W-1:0]   tail_plus1;
    decoded_inst_t      head_inst;
    decoded_inst_t      next_inst;

    logic               enq_fire;
    logic               deq_fire;
    logic [1:0]         enq_num;
    logic [1:0]         deq_num;

    logic               head_is_alu;
    logic               next_is_alu;
    logic               raw_hazard;
    logic               waw_hazard;
    logic               pair_ok;

    logic [DEPTH-1:0]   wr_en;
    logic [DEPTH-1:0]   wr_sel;

    assign head_plus1 = head_q + PTR_W'(1);
    assign tail_plus1 = tail_q + PTR_W'(1);
    assign head_inst  = mem_q[head_q];
    assign next_inst  = mem_q[head_plus1];

    // Credit is based on the pre-issue count only; issued entries free space next cycle.
    assign in_ready  = (count_q <= CNT_W'(DEPTH - 2));
    assign enq_fire  = in_ready && in_valid[0];
    assign enq_num   = enq_fire ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;

    assign head_is_alu = head_inst.is_alu1_op | head_inst.is_alu2_op;
    assign next_is_alu = next_inst.is_alu1_op | next_inst.is_alu2_op;

    assign raw_hazard = head_inst.rf_we &&
                        ((next_inst.use_src1 && (next_inst.src1 == head_inst.dest)) ||
                         (next_inst.use_src2 && (next_inst.src2 == head_inst.dest)));
    assign waw_hazard = head_inst.rf_we && next_inst.rf_we &&
                        (head_inst.dest == next_inst.dest);

    assign pair_ok = !head_inst.is_br_op && !head_inst.is_mul_div_op && !head_inst.is_sp_op &&
                     next_is_alu && !next_inst.is_br_op && !raw_hazard && !waw_hazard;

    always_comb begin
        out_valid = 2'b00;
        if (count_q >= CNT_W'(2)) begin
            out_valid[0] = 1'b1;
            out_valid[1] = head_inst.is_br_op || pair_ok;
        end else if (count_q == CNT_W'(1)) begin
            // A lone branch waits for its delay slot.
            out_valid[0] = !head_inst.is_br_op;
        end
    end

    // Steer the ALU ops so slot 0 always uses ALU1 and slot 1 always uses ALU2.
    always_comb begin
        out_inst[0] = head_inst;
        out_inst[1] = next_inst;
        if (head_is_alu) begin
            out_inst[0].is_alu1_op = 1'b1;
            out_inst[0].is_alu2_op = 1'b0;
        end
        if (next_is_alu) begin
            out_inst[1].is_alu1_op = 1'b0;
            out_inst[1].is_alu2_op = 1'b1;
        end
    end

    assign deq_fire  = out_ready && out_valid[0];
    assign deq_num   = deq_fire ? ({1'b0, out_valid[0]} + {1'b0, out_valid[1]}) : 2'd0;
    assign occupancy = count_q;

    always_comb begin
        head_d  = head_q + PTR_W'(deq_num);
        tail_d  = tail_q + PTR_W'(enq_num);
        count_d = count_q + CNT_W'(enq_num) - CNT_W'(deq_num);
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Per-entry write decode: slot 0 lands at tail, slot 1 at tail+1.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr
            assign wr_sel[gi] = in_valid[1] && (tail_plus1 == PTR_W'(gi));
            assign wr_en[gi]  = enq_fire && !flush &&
                                ((tail_q == PTR_W'(gi)) || wr_sel[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_q[i] <= wr_sel[i] ? in_inst[1] : in_inst[0];
            end
        end
    end

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!resetn)
        !(in_valid[0] && !in_ready));
    a_in_valid_legal: assert property (@(posedge clk) disable iff (!resetn)
        in_valid != 2'b10);
    a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
        count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_issue_queue.sv
// Directed and randomized checks of issue_queue against a queue-based reference
// model that applies the pairing rules directly to the buffered instructions.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int K_ALU1 = 0, K_ALU2 = 1, K_BR = 2, K_MD = 3, K_SP = 4, K_LS = 5;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 flush;
    logic [1:0]           in_valid;
    decoded_inst_t [1:0]  in_inst;
    logic                 in_ready;
    logic [1:0]           out_valid;
    decoded_inst_t [1:0]  out_inst;
    logic                 out_ready;
    logic [PTR_W:0]       occupancy;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    decoded_inst_t mq[$];
    int            errors = 0;
    int            checks = 0;
    int unsigned   pc_ctr = 32'h100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic decoded_inst_t mk(input int kind, input logic [5:0] d, input logic [5:0] s1,
                                         input logic [5:0] s2, input logic we, input logic u1,
                                         input logic u2);
        decoded_inst_t x;
        x = '0;
        x.pc = pc_ctr;
        pc_ctr += 4;
        x.dest = d;
        x.src1 = s1;
        x.src2 = s2;
        x.rf_we = we;
        x.use_src1 = u1;
        x.use_src2 = u2;
        x.is_alu1_op = (kind == K_ALU1);
        x.is_alu2_op = (kind == K_ALU2);
        x.is_br_op = (kind == K_BR);
        x.is_mul_div_op = (kind == K_MD);
        x.is_sp_op = (kind == K_SP);
        x.is_ls_op = (kind == K_LS);
        return x;
    endfunction

    function automatic decoded_inst_t addu(input logic [5:0] d, input logic [5:0] s1, input logic [5:0] s2);
        return mk(K_ALU1, d, s1, s2, 1'b1, 1'b1, 1'b1);
    endfunction

    function automatic logic [5:0] rnd_reg();
        if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) == 0) ? REG_HI : REG_LO;
        return 6'($urandom_range(0, 5));
    endfunction

    function automatic decoded_inst_t rnd_inst();
        int k;
        int kind;
        k = $urandom_range(0, 9);
        kind = (k <= 3) ? K_ALU1 : (k <= 5) ? K_ALU2 : (k == 6) ? K_BR :
               (k == 7) ? K_MD : (k == 8) ? K_SP : K_LS;
        return mk(kind, rnd_reg(), rnd_reg(), rnd_reg(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    function automatic logic is_alu(input decoded_inst_t x);
        return x.is_alu1_op | x.is_alu2_op;
    endfunction

    // Issue pair as decided by the dual-issue rules, from the model queue contents.
    function automatic logic [1:0] model_valid();
        decoded_inst_t h;
        decoded_inst_t s;
        logic raw;
        logic waw;
        if (mq.size() == 0) return 2'b00;
        h = mq[0];
        if (h.is_br_op) return (mq.size() >= 2) ? 2'b11 : 2'b00;
        if (mq.size() < 2) return 2'b01;
        s = mq[1];
        raw = h.rf_we && ((s.use_src1 && s.src1 == h.dest) || (s.use_src2 && s.src2 == h.dest));
        waw = h.rf_we && s.rf_we && h.dest == s.dest;
        if (h.is_mul_div_op || h.is_sp_op || !is_alu(s) || s.is_br_op || raw || waw) return 2'b01;
        return 2'b11;
    endfunction

    function automatic decoded_inst_t steer(input decoded_inst_t x, input int slot);
        decoded_inst_t y;
        y = x;
        if (is_alu(x)) begin
            y.is_alu1_op = (slot == 0);
            y.is_alu2_op = (slot == 1);
        end
        return y;
    endfunction

    task automatic cycle(input logic [1:0] iv, input decoded_inst_t i0, input decoded_inst_t i1,
                         input logic ordy, input logic fl);
        logic [1:0] ev;
        logic       er;
        in_valid   = iv;
        in_inst[0] = i0;
        in_inst[1] = i1;
        out_ready  = ordy;
        flush      = fl;
        #1;
        ev = model_valid();
        er = (DEPTH - mq.size()) >= 2;
        if (resetn) begin
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'(er));
            chk("occupancy", 64'(occupancy), 64'(mq.size()));
            if (ev[0]) chk("slot0_inst", 64'(out_inst[0]), 64'(steer(mq[0], 0)));
            if (ev[1]) chk("slot1_inst", 64'(out_inst[1]), 64'(steer(mq[1], 1)));
        end
        @(posedge clk);
        if (!resetn || fl) begin
            mq.delete();
        end else begin
            if (ordy && ev[0]) begin
                void'(mq.pop_front());
                if (ev[1]) void'(mq.pop_front());
            end
            if (er && iv[0]) begin
                mq.push_back(i0);
                if (iv[1]) mq.push_back(i1);
            end
        end
        $display("t=%0t in_valid=%b out_ready=%b flush=%b out_valid=%b model_occ=%0d",
                 $time, iv, ordy, fl, ev, mq.size());
        @(negedge clk);
    endtask

    decoded_inst_t nop, a, b, c, d, br, lw, mult, mfhi;
    logic [1:0]    rv;

    initial begin
        nop = '0;
        resetn = 1'b0;
        flush = 1'b0;
        in_valid = 2'b00;
        in_inst = '0;
        out_ready = 1'b0;
        @(negedge clk);
        cycle(2'b00, nop, nop, 1'b0, 1'b0);
        cycle(2'b00, nop, nop, 1'b0, 1'b0);
        resetn = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_occupancy", 64'(occupancy), 64'd0);

        // Two independent ADDUs dual-issue, slot 1 steered to ALU2.
        cycle(2'b11, addu(3, 1, 2), addu(4, 1, 2), 1'b0, 1'b0);
        chk("addu_pair_valid", 64'(out_valid), 64'd3);
        chk("addu_slot1_alu2", 64'(out_inst[1].is_alu2_op), 64'd1);
        cycle(2'b00, nop, nop, 1'b1, 1'b0);
        chk("addu_drained", 64'(occupancy), 64'd0);

        // RAW dependence serialises the pair.
        cycle(2'b11, addu(5, 1, 2), addu(6, 5, 0), 1'b0, 1'b0);
        chk("raw_single", 64'(out_valid), 64'd1);
        cycle(2'b00, nop, nop, 1'b1, 1'b0);
        chk("raw_second_alone", 64'(out_valid), 64'd1);
        cycle(2'b00, nop, nop, 1'b1, 1'b0);

        // Branch waits for its delay slot.
        br = mk(K_BR, 0, 1, 2, 1'b0, 1'b1, 1'b1);
        lw = mk(K_LS, 9, 29, 0, 1'b1, 1'b1, 1'b0);
        cycle(2'b01, br, nop, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(2'b00, nop, nop, 1'b1, 1'b0);
        chk("br_alone_blocked", 64'(out_valid), 64'd0);
        cycle(2'b01, lw, nop, 1'b1, 1'b0);
        chk("br_ds_pair", 64'(out_valid), 64'd3);
        chk("br_ds_slot1_pc", 64'(out_inst[1].pc), 64'(lw.pc));
        cycle(2'b00, nop, nop, 1'b1, 1'b0);

        // Fill to DEPTH, then issue across the wrap boundary.
        a = addu(7, 1, 2);
        b = addu(8, 7, 1);
        c = addu(9, 1, 2);
        d = addu(11, 1, 2);
        cycle(2'b11, a, b, 1'b0, 1'b0);
        cycle(2'b11, c, d, 1'b0, 1'b0);
        cycle(2'b11, addu(12, 1, 2), addu(13, 1, 2), 1'b0, 1'b0);
        cycle(2'b11, addu(14, 1, 2), addu(15, 1, 2), 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_occupancy", 64'(occupancy), 64'd8);
        cycle(2'b00, nop, nop, 1'b1, 1'b0);
        chk("cnt7_in_ready", 64'(in_ready), 64'd0);
        chk("cnt7_occupancy", 64'(occupancy), 64'd7);
        chk("wrap_pair_valid", 64'(out_valid), 64'd3);
        chk("wrap_slot0_pc", 64'(out_inst[0].pc), 64'(b.pc));
        chk("wrap_slot1_pc", 64'(out_inst[1].pc), 64'(c.pc));
        for (int i = 0; i < 4; i++) cycle(2'b00, nop, nop, 1'b1, 1'b0);
        chk("wrap_drained", 64'(occupancy), 64'd0);

        // Flush beats simultaneous enqueue and issue.
        cycle(2'b11, addu(16, 1, 2), addu(17, 1, 2), 1'b0, 1'b0);
        cycle(2'b01, addu(18, 1, 2), nop, 1'b0, 1'b0);
        cycle(2'b11, addu(19, 1, 2), addu(20, 1, 2), 1'b1, 1'b1);
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);

        // MULT writes HI; MFHI may not pair behind a mul/div head.
        mult = mk(K_MD, REG_HI, 1, 2, 1'b1, 1'b1, 1'b1);
        mfhi = mk(K_ALU2, 10, REG_HI, 0, 1'b1, 1'b1, 1'b0);
        cycle(2'b11, mult, mfhi, 1'b0, 1'b0);
        chk("mult_single", 64'(out_valid), 64'd1);
        cycle(2'b00, nop, nop, 1'b1, 1'b0);
        chk("mfhi_slot0_valid", 64'(out_valid), 64'd1);
        chk("mfhi_slot0_pc", 64'(out_inst[0].pc), 64'(mfhi.pc));
        chk("mfhi_slot0_alu1", 64'(out_inst[0].is_alu1_op), 64'd1);
        cycle(2'b00, nop, nop, 1'b1, 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rv = 2'b00;
            if (mq.size() <= DEPTH - 2) begin
                case ($urandom_range(0, 2))
                    0: rv = 2'b00;
                    1: rv = 2'b01;
                    default: rv = 2'b11;
                endcase
            end
            a = rnd_inst();
            b = rnd_inst();
            cycle(rv, a, b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
